rom_block_reader: RTL

Bus-master counterpart to the boot ROM's async read port. It drives rom_addr/rom_ce_n, waits a fixed access time, and samples rom_data. Each fetched byte is written to a destination memory port over a strobe/ack handshake. It replaces the boot-code copy loop (ROM block to RAM at 6000h) with hardware, used during startup and ROM shadowing.

---
 rtl/rom_block_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rom_block_reader.sv
// ROM-to-memory block copier: drives the boot ROM's async read port, waits the
// access time, then writes each byte over a strobe/ack handshake.
module rom_block_reader #(
  parameter int unsigned WAIT_CYC = 3,
  parameter int unsigned LEN_W    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [15:0]      rom_addr,
  output logic             rom_ce_n,
  input  logic [7:0]       rom_data,
  output logic [15:0]      wr_addr,
  output logic [7:0]       wr_data,
  output logic             wr_stb,
  input  logic             wr_ack
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYC);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ce_n_q, ce_n_d;
  logic             stb_q, stb_d;
  logic [15:0]      rom_addr_q, rom_addr_d;
  logic [15:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ce_n_d     = ce_n_q;
    stb_d      = stb_q;
    rom_addr_d = rom_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = length;
          if (length != '0) begin
            state_d    = StRead;
            wait_d     = WaitInit;
            busy_d     = 1'b1;
            ce_n_d     = 1'b0;
            rom_addr_d = src_addr;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        if (wait_q == 4'd0) begin
          // ROM access time has elapsed: capture the byte and release the ROM
          wr_data_d = rom_data;
          ce_n_d    = 1'b1;
          stb_d     = 1'b1;
          wr_addr_d = dst_q;
          state_d   = StWrite;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StWrite: begin
        if (wr_ack) begin
          src_d = src_q + 16'd1;
          dst_d = dst_q + 16'd1;
          rem_d = rem_q - LEN_W'(1);
          stb_d = 1'b0;
          if (rem_d == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = StRead;
            wait_d     = WaitInit;
            ce_n_d     = 1'b0;
            rom_addr_d = src_q + 16'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= 4'd0;
      src_q      <= 16'h0000;
      dst_q      <= 16'h0000;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      stb_q      <= 1'b0;
      rom_addr_q <= 16'h0000;
      wr_addr_q  <= 16'h0000;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ce_n_q     <= ce_n_d;
      stb_q      <= stb_d;
      rom_addr_q <= rom_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_ce_n = ce_n_q;
  assign rom_addr = rom_addr_q;
  assign wr_stb   = stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
